// File: rtl/sp_fetch_ctrl_pkg.sv
// Shared types and constants for the SP instruction-fetch sequencer.
// Holds the FSM state encoding, default sizing, error codes and the fetch-address check.
package sp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_MEM,
        ST_ISSUE,
        ST_EXEC,
        ST_DONE,
        ST_ERR
    } sp_fc_state_t;

    localparam int SP_MAX_LATENCY = 10;
    localparam int SP_IMEM_DEPTH  = 1024;

    localparam logic [1:0] SP_ERR_NONE    = 2'd0;
    localparam logic [1:0] SP_ERR_RANGE   = 2'd1;
    localparam logic [1:0] SP_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] SP_ERR_PROTO   = 2'd3;

    // A fetch address is usable when word aligned and inside the ROM.
    function automatic logic sp_addr_ok(input logic [31:0] pc, input logic [31:0] depth);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < depth);
    endfunction

endpackage

// File: rtl/sp_fetch_ctrl_if.sv
// Instruction-ROM and SP handshake bundle between the fetch sequencer and its environment.
// The master modport is the sequencer side; slave is the ROM/SP side.
interface sp_fetch_ctrl_if #(
    parameter int IMEM_DEPTH = 1024
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          imem_re;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          sp_in_valid;
    logic [31:0]   sp_inst;
    logic          sp_out_valid;
    logic [31:0]   sp_inst_addr;

    modport master (
        output imem_re, imem_addr, sp_in_valid, sp_inst,
        input  imem_rdata, sp_out_valid, sp_inst_addr
    );

    modport slave (
        input  imem_re, imem_addr, sp_in_valid, sp_inst,
        output imem_rdata, sp_out_valid, sp_inst_addr
    );
endinterface

// File: rtl/sp_fetch_ctrl_watchdog.sv
// Execution-latency watchdog: counts enabled cycles since the last clear.
// o_expired is high during the last allowed cycle, so a miss in that cycle is a timeout.
module sp_watchdog
    import sp_pkg::*;
#(
    parameter int MAX_LATENCY = SP_MAX_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(MAX_LATENCY + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(MAX_LATENCY))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == CW'(MAX_LATENCY - 1));

endmodule

// File: rtl/sp_fetch_ctrl.sv
// Instruction-fetch sequencer: reads the ROM at the SP program counter, issues one instruction
// at a time, waits for completion and tracks retired count and protocol/range/timeout errors.
module sp_fetch_ctrl
    import sp_pkg::*;
#(
    parameter int IMEM_DEPTH  = SP_IMEM_DEPTH,
    parameter int MAX_LATENCY = SP_MAX_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] inst_limit,
    sp_fetch_ctrl_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             proto_err,
    output logic             range_err,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam int AW = $clog2(IMEM_DEPTH);

    sp_fc_state_t     r_state, w_next;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_limit, r_retired, w_retired_inc;
    logic             r_abort, r_timeout, r_proto, r_range;
    logic [31:0]      r_inst;
    logic             r_in_valid;
    logic             w_accept, w_clear, w_retire, w_expired, w_pc_ok, w_re;
    logic [1:0]       w_err;

    assign w_pc_ok       = sp_addr_ok(r_pc, 32'(IMEM_DEPTH));
    assign w_retired_inc = (&r_retired) ? r_retired : r_retired + 1'b1;

    sp_watchdog #(.MAX_LATENCY(MAX_LATENCY)) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (r_state == ST_ISSUE),
        .i_en      (r_state == ST_EXEC),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clear  = 1'b0;
        w_retire = 1'b0;
        w_err    = SP_ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next   = ST_FETCH;
                    w_accept = 1'b1;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (!w_pc_ok) begin
                    w_next = ST_ERR;
                    w_err  = SP_ERR_RANGE;
                end else begin
                    w_next = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: w_next = abort ? ST_IDLE : ST_ISSUE;
            // The pulse is already on the wire in ISSUE, so abort here only gets latched.
            ST_ISSUE:    w_next = ST_EXEC;
            ST_EXEC: begin
                if (bus.sp_out_valid) begin
                    w_retire = 1'b1;
                    if (((r_limit != '0) && (w_retired_inc == r_limit)) || r_abort || abort)
                        w_next = ST_DONE;
                    else
                        w_next = ST_FETCH;
                end else if (w_expired) begin
                    w_next = ST_ERR;
                    w_err  = SP_ERR_TIMEOUT;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end else if (start) begin
                    w_next   = ST_FETCH;
                    w_accept = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // A completion outside EXEC overrides everything else.
        if (bus.sp_out_valid && (r_state != ST_EXEC)) begin
            w_next   = ST_ERR;
            w_err    = SP_ERR_PROTO;
            w_accept = 1'b0;
            w_clear  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_limit    <= '0;
            r_retired  <= '0;
            r_abort    <= 1'b0;
            r_timeout  <= 1'b0;
            r_proto    <= 1'b0;
            r_range    <= 1'b0;
            r_inst     <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_valid <= (w_next == ST_ISSUE);
            if (w_accept) begin
                r_limit   <= inst_limit;
                r_retired <= '0;
                r_abort   <= 1'b0;
            end else begin
                if (w_retire)
                    r_retired <= w_retired_inc;
                if (abort && ((r_state == ST_ISSUE) || (r_state == ST_EXEC)))
                    r_abort <= 1'b1;
            end
            if (w_accept || w_clear) begin
                r_timeout <= 1'b0;
                r_proto   <= 1'b0;
                r_range   <= 1'b0;
            end else begin
                if (w_err == SP_ERR_TIMEOUT) r_timeout <= 1'b1;
                if (w_err == SP_ERR_PROTO)   r_proto   <= 1'b1;
                if (w_err == SP_ERR_RANGE)   r_range   <= 1'b1;
            end
            if (w_retire)
                r_pc <= bus.sp_inst_addr;
            if (r_state == ST_WAIT_MEM)
                r_inst <= bus.imem_rdata;
        end
    end

    assign w_re            = (r_state == ST_FETCH) && w_pc_ok;
    assign bus.imem_re     = w_re;
    assign bus.imem_addr   = w_re ? r_pc[AW+1:2] : '0;
    assign bus.sp_in_valid = r_in_valid;
    assign bus.sp_inst     = r_inst;

    assign busy        = (r_state != ST_IDLE) && (r_state != ST_ERR);
    assign done        = (r_state == ST_DONE);
    assign timeout_err = r_timeout;
    assign proto_err   = r_proto;
    assign range_err   = r_range;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_sp_fetch_ctrl.sv
// Directed bench for sp_fetch_ctrl with a synchronous ROM model and a scripted SP responder.
module tb_sp_fetch_ctrl;
    import sp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] inst_limit = '0;
    logic        busy, done, timeout_err, proto_err, range_err;
    logic [15:0] retired_cnt;

    sp_fetch_ctrl_if #(.IMEM_DEPTH(1024)) bus ();

    sp_fetch_ctrl #(.IMEM_DEPTH(1024), .MAX_LATENCY(10), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .inst_limit  (inst_limit),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .proto_err   (proto_err),
        .range_err   (range_err),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // ROM content is a recognisable function of the word index.
    always @(posedge clk) begin
        if (bus.imem_re) bus.imem_rdata <= 32'hC0DE_0000 | 32'(bus.imem_addr);
    end

    int mon_re = 0, mon_done = 0, mon_inv = 0;
    int mon_addr[$];
    always @(negedge clk) begin
        if (bus.imem_re) begin
            mon_re <= mon_re + 1;
            mon_addr.push_back(int'(bus.imem_addr));
        end
        if (done)            mon_done <= mon_done + 1;
        if (bus.sp_in_valid) mon_inv  <= mon_inv + 1;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic kick(input logic [15:0] lim);
        start = 1'b1;
        inst_limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_in_valid(input string tag, output logic [31:0] inst);
        int k = 0;
        while (!bus.sp_in_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_in_valid_seen"}, 32'(bus.sp_in_valid), 32'd1);
        inst = bus.sp_inst;
    endtask

    // Completes the outstanding instruction in EXEC cycle 'delay' with new PC 'pc'.
    task automatic sp_respond(input string tag, input int delay, input logic [31:0] pc,
                              output logic [31:0] inst);
        wait_in_valid(tag, inst);
        repeat (delay) tick();
        bus.sp_out_valid = 1'b1;
        bus.sp_inst_addr = pc;
        tick();
        bus.sp_out_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] inst;
        int base_re, base_done, base_inv, base_q;

        bus.sp_out_valid = 1'b0;
        bus.sp_inst_addr = '0;

        // Reset state
        tick();
        check("rst_flags", {25'd0, busy, done, timeout_err, proto_err, range_err,
                            bus.imem_re, bus.sp_in_valid}, 32'd0);
        check("rst_retired", 32'(retired_cnt), 32'd0);
        check("rst_inst", bus.sp_inst, 32'd0);
        rst_n = 1'b1;
        tick();

        // Run of three sequential instructions
        base_q = mon_addr.size();
        base_done = mon_done;
        kick(16'd3);
        check("r1_fetch_re", 32'(bus.imem_re), 32'd1);
        check("r1_busy", 32'(busy), 32'd1);
        sp_respond("r1_i0", 2, 32'd4, inst);
        check("r1_inst0", inst, 32'hC0DE_0000);
        sp_respond("r1_i1", 2, 32'd8, inst);
        check("r1_inst1", inst, 32'hC0DE_0001);
        sp_respond("r1_i2", 2, 32'd12, inst);
        check("r1_inst2", inst, 32'hC0DE_0002);
        check("r1_done", 32'(done), 32'd1);
        check("r1_retired", 32'(retired_cnt), 32'd3);
        tick();
        check("r1_done_low", 32'(done), 32'd0);
        check("r1_idle", 32'(busy), 32'd0);
        check("r1_addr0", 32'(mon_addr[base_q]), 32'd0);
        check("r1_addr1", 32'(mon_addr[base_q+1]), 32'd1);
        check("r1_addr2", 32'(mon_addr[base_q+2]), 32'd2);
        check("r1_done_cnt", 32'(mon_done - base_done), 32'd1);
        check("r1_pc", dut.r_pc, 32'd12);

        // Resume at persisted PC, then branch to 0x40
        kick(16'd2);
        check("br_resume_addr", 32'(bus.imem_addr), 32'd3);
        sp_respond("br_i0", 1, 32'h40, inst);
        check("br_target_re", 32'(bus.imem_re), 32'd1);
        check("br_target_addr", 32'(bus.imem_addr), 32'd16);
        sp_respond("br_i1", 1, 32'h44, inst);
        check("br_done", 32'(done), 32'd1);
        check("br_retired", 32'(retired_cnt), 32'd2);
        tick();

        // Range error: unaligned target
        kick(16'd0);
        sp_respond("rg1", 1, 32'h1002, inst);
        check("rg1_no_re", 32'(bus.imem_re), 32'd0);
        check("rg1_retired", 32'(retired_cnt), 32'd1);
        tick();
        check("rg1_range", 32'(range_err), 32'd1);
        check("rg1_err_state", 32'(busy), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("rg1_abort_clr", 32'(range_err), 32'd0);

        // Range error: word 1024, then a retry from ERR fails again
        do_reset();
        kick(16'd0);
        sp_respond("rg2", 1, 32'h1000, inst);
        check("rg2_no_re", 32'(bus.imem_re), 32'd0);
        tick();
        check("rg2_range", 32'(range_err), 32'd1);
        kick(16'd0);
        check("rg2_retry_clr", 32'(range_err), 32'd0);
        check("rg2_retry_no_re", 32'(bus.imem_re), 32'd0);
        tick();
        check("rg2_retry_range", 32'(range_err), 32'd1);
        do_reset();

        // Watchdog: answer in EXEC cycle 10 is accepted
        kick(16'd1);
        sp_respond("wd_ok", 10, 32'd4, inst);
        check("wd_ok_done", 32'(done), 32'd1);
        check("wd_ok_no_to", 32'(timeout_err), 32'd0);
        tick();
        // Silent SP: timeout after EXEC cycle 10
        kick(16'd1);
        wait_in_valid("wd_to", inst);
        repeat (10) tick();
        check("wd_c10_no_to", 32'(timeout_err), 32'd0);
        check("wd_c10_busy", 32'(busy), 32'd1);
        tick();
        check("wd_timeout", 32'(timeout_err), 32'd1);
        check("wd_err_state", 32'(busy), 32'd0);

        // Spurious completion in WAIT_MEM, then restart from ERR at same PC
        kick(16'd1);
        check("sp_clr_to", 32'(timeout_err), 32'd0);
        check("sp_fetch_addr", 32'(bus.imem_addr), 32'd1);
        tick();
        bus.sp_out_valid = 1'b1;
        tick();
        bus.sp_out_valid = 1'b0;
        check("sp_proto", 32'(proto_err), 32'd1);
        check("sp_err_state", 32'(busy), 32'd0);
        kick(16'd1);
        check("sp_restart_clr", 32'(proto_err), 32'd0);
        check("sp_restart_addr", 32'(bus.imem_addr), 32'd1);
        sp_respond("sp_i0", 2, 32'd8, inst);
        check("sp_done", 32'(done), 32'd1);
        tick();

        // Abort in EXEC with unbounded limit
        kick(16'd0);
        wait_in_valid("ab_exec", inst);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        bus.sp_out_valid = 1'b1;
        bus.sp_inst_addr = 32'hC;
        tick();
        bus.sp_out_valid = 1'b0;
        check("ab_exec_done", 32'(done), 32'd1);
        check("ab_exec_retired", 32'(retired_cnt), 32'd1);
        tick();

        // Abort in WAIT_MEM
        base_inv = mon_inv;
        base_done = mon_done;
        base_re = mon_re;
        kick(16'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_wm_idle", 32'(busy), 32'd0);
        repeat (4) tick();
        check("ab_wm_no_inv", 32'(mon_inv - base_inv), 32'd0);
        check("ab_wm_no_done", 32'(mon_done - base_done), 32'd0);
        check("ab_wm_one_read", 32'(mon_re - base_re), 32'd1);

        // Start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-run
        kick(16'd0);
        wait_in_valid("ar", inst);
        tick();
        check("ar_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_busy_low", 32'(busy), 32'd0);
        check("ar_pc", dut.r_pc, 32'd0);
        check("ar_inst", bus.sp_inst, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sp_fetch_ctrl.md
# sp_fetch_ctrl

Instruction-fetch sequencer for the single-issue simple processor (SP). It reads instruction words from a synchronous instruction ROM at the SP's current `inst_addr` and hands each one to the SP with a one-cycle `in_valid` pulse. It then waits for the SP's `out_valid`, captures the updated `inst_addr`, and repeats until an instruction limit is reached. It also flags protocol violations: latency timeout, spurious `out_valid`, and bad fetch addresses.

## Interface
- `IMEM_DEPTH`, 1024: instruction ROM depth in 32-bit words.
- `MAX_LATENCY`, 10: maximum EXEC cycles allowed between the `sp_in_valid` pulse and `sp_out_valid`.
- `CNT_W`, 16: width of the limit and retired counters.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle run request.
- `abort` in 1: stops the run.
- `inst_limit` in CNT_W: number of instructions to retire; sampled when `start` is accepted. 0 means unbounded.
- `imem_re` out 1: ROM read enable.
- `imem_addr` out $clog2(IMEM_DEPTH): ROM word index.
- `imem_rdata` in 32: ROM data, valid the cycle after `imem_re`.
- `sp_in_valid` out 1: instruction-valid pulse to the SP (registered).
- `sp_inst` out 32: instruction to the SP (registered).
- `sp_out_valid` in 1: SP completion.
- `sp_inst_addr` in 32: SP program counter, valid with `sp_out_valid`.
- `busy` out 1: high in every state except IDLE and ERR.
- `done` out 1: one-cycle pulse when the run ends normally.
- `timeout_err`, `proto_err`, `range_err` out 1: sticky error flags.
- `retired_cnt` out CNT_W: instructions retired in the current run.

## Operation
- States: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, DONE, ERR.
- IDLE:
  - `start` → FETCH.
  - On acceptance: latch `inst_limit` into `limit_q`; clear `retired_cnt` and all error flags.
- FETCH:
  - Checks `pc_q`. If `pc_q[1:0]!=0` or `pc_q>>2 >= IMEM_DEPTH`: set `range_err`, go to ERR, no read issued.
  - Otherwise: `imem_re=1`, `imem_addr=pc_q>>2`, → WAIT_MEM.
- WAIT_MEM: register `imem_rdata` into `sp_inst`; → ISSUE.
- ISSUE:
  - `sp_in_valid=1` for exactly this cycle.
  - Clear the watchdog; → EXEC.
  - `sp_inst` holds its value outside ISSUE.
- EXEC:
  - Watchdog increments each cycle.
  - On `sp_out_valid`:
    - `pc_q <= sp_inst_addr`; `retired_cnt++`.
    - → DONE if `limit_q!=0` and the new count equals `limit_q`, or if `abort` was latched during the run.
    - Otherwise → FETCH.
  - If the watchdog reaches MAX_LATENCY without `sp_out_valid`: set `timeout_err`, → ERR.
- DONE: `done=1` for one cycle; → IDLE.
- ERR:
  - Outputs idle; flags hold.
  - `start` clears the flags and begins a new run exactly as from IDLE.
  - `abort` → IDLE with flags cleared.
- `pc_q`:
  - Resets to 0, matching the SP's reset PC.
  - Persists across runs, so a new run resumes where the SP stopped.
- Protocol check: `sp_out_valid` high in any state other than EXEC sets `proto_err` and → ERR. This takes priority over normal transitions.
- `abort`:
  - In FETCH, WAIT_MEM or ISSUE-before-pulse: → IDLE at the next edge, no `done`. Exception: if ISSUE has already asserted `sp_in_valid`, the instruction completes.
  - In EXEC: latched; the in-flight instruction completes, then → DONE.
  - In IDLE: no effect.
- `start` while `busy`: ignored.
- Simultaneous `start` and `abort` in IDLE or ERR: `abort` wins.
- `retired_cnt` saturates at all-ones and does not wrap.

## Timing
- Reset values: all outputs 0; `pc_q=0`; state IDLE.
- Cycle 0: `start` sampled.
- Cycle 1 (FETCH): `imem_re` high.
- Cycle 2 (WAIT_MEM): `imem_rdata` valid, captured at the cycle-2 edge.
- Cycle 3 (ISSUE): `sp_in_valid` high.
- Cycle 4 onward (EXEC): the first cycle in which `sp_out_valid` is accepted.
- Per-instruction period is 3 + EXEC cycles; minimum 4.
- Watchdog: `sp_out_valid` must arrive by EXEC cycle MAX_LATENCY (inclusive). With MAX_LATENCY=10, arrival in EXEC cycle 10 passes; no arrival by the end of cycle 10 raises `timeout_err` at that edge.
- `done` is asserted in the cycle after the final `sp_out_valid`.
- Asynchronous reset mid-run: immediate return to reset values, including `pc_q`.

## Structure
- Package `sp_pkg`:
  - state enum `sp_fc_state_t`
  - `SP_MAX_LATENCY=10`
  - `SP_IMEM_DEPTH=1024`
  - error-code constants
- Sub-module `sp_watchdog`: clear/enable counter with a `expired` compare output at MAX_LATENCY.

## Test plan
- Run, limit 3: reset, `start` with `inst_limit=3`; SP model answers in 2 cycles with PCs 4, 8, 12 → `imem_addr` sequence 0, 1, 2; `retired_cnt=3`; `done` pulses once; `pc_q=12`.
- Branch target: SP returns `sp_inst_addr=0x40` → next `imem_addr=16`.
- Range error: SP returns `0x1002` (unaligned) → FETCH raises `range_err`, no `imem_re`, state ERR. A separate case returns `0x1000` (word 1024) → `range_err`.
- Watchdog boundary: `sp_out_valid` in EXEC cycle 10 → accepted; SP silent through cycle 10 → `timeout_err` set and ERR.
- Spurious completion: `sp_out_valid` asserted during WAIT_MEM → `proto_err`, ERR; a subsequent `start` clears the flags and resumes at the same `pc_q`.
- Abort: `abort` in EXEC with `limit=0` → instruction retires, `done` pulses, `retired_cnt` correct. `abort` in WAIT_MEM → IDLE with no `sp_in_valid` and no `done`.
